// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - HD44780 opcodes, DDRAM line map and receiver FSM states
package lcd_pkg;

    localparam logic [7:0] CLR   = 8'h01;
    localparam logic [7:0] HOME  = 8'h02;
    localparam logic [7:0] ENTRY = 8'h04;
    localparam logic [7:0] DISP  = 8'h08;
    localparam logic [7:0] SHIFT = 8'h10;
    localparam logic [7:0] FUNC  = 8'h20;
    localparam logic [7:0] CGRAM = 8'h40;
    localparam logic [7:0] DDRAM = 8'h80;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE_LEN   = 7'd40;
    localparam logic [6:0] LINE0_LAST = LINE0_BASE + LINE_LEN - 7'd1;
    localparam logic [6:0] LINE1_LAST = LINE1_BASE + LINE_LEN - 7'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_HOLD
    } lcd_state_t;

    // Two-line address counter step; unmapped addresses fall back to a line edge.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic mapped;
        mapped = (a <= LINE0_LAST) || (a >= LINE1_BASE && a <= LINE1_LAST);
        if (inc) begin
            if (!mapped || a == LINE1_LAST) return LINE0_BASE;
            else if (a == LINE0_LAST)       return LINE1_BASE;
            else                            return a + 7'd1;
        end else begin
            if (!mapped || a == LINE0_BASE) return LINE1_LAST;
            else if (a == LINE1_BASE)       return LINE0_LAST;
            else                            return a - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// rtl/lcd_bus_sync.sv - bus input synchroniser and E falling-edge strobe
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_d,
    output logic       strobe,
    output logic       rs,
    output logic       rw,
    output logic [7:0] d
);

    logic [10:0] sync_q [SYNC_STAGES];
    logic        e_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_prev <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_d};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            e_prev <= sync_q[SYNC_STAGES-1][10];
        end
    end

    // Strobe is combinational so the top registers the decode one cycle later.
    assign strobe = e_prev && !sync_q[SYNC_STAGES-1][10];
    assign rs     = sync_q[SYNC_STAGES-1][9];
    assign rw     = sync_q[SYNC_STAGES-1][8];
    assign d      = sync_q[SYNC_STAGES-1][7:0];

endmodule

// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - HD44780 write-bus mirror with shadow DDRAM and busy emulation
import lcd_pkg::*;

module lcd_bus_receiver #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BUSY_CYCLES = CLK_HZ / 25_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_d,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       data_valid,
    output logic [6:0] ddram_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       err_busy_write,
    output logic       err_mode
);

    localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES - 1);

    logic       strobe, bus_rs, bus_rw;
    logic [7:0] bus_d;

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (CLOCK_50),
        .reset  (reset),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_d  (lcd_d),
        .strobe (strobe),
        .rs     (bus_rs),
        .rw     (bus_rw),
        .d      (bus_d)
    );

    lcd_state_t        state_q, state_d;
    logic [6:0]        fill_cnt;
    logic [BUSY_W-1:0] busy_cnt;
    logic              inc_q;
    logic [7:0]        ddram_mem [128];

    logic xfer, data_wr, instr, is_clear;
    assign xfer     = strobe && !bus_rw;
    assign data_wr  = xfer && bus_rs;
    assign instr    = xfer && !bus_rs;
    assign is_clear = instr && (bus_d == CLR);
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (is_clear)  state_d = ST_CLEAR;
                else if (xfer) state_d = ST_HOLD;
            end
            ST_CLEAR: begin
                if (is_clear)                 state_d = ST_CLEAR;
                else if (fill_cnt == 7'h7F)   state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (is_clear)               state_d = ST_CLEAR;
                else if (xfer)              state_d = ST_HOLD;
                else if (busy_cnt == '0)    state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= ST_CLEAR;
            fill_cnt <= '0;
            busy_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (is_clear)                fill_cnt <= '0;
            else if (state_q == ST_CLEAR) fill_cnt <= fill_cnt + 7'd1;
            // Reload on entry to HOLD and on every transfer that lands in HOLD.
            if (state_d == ST_HOLD && (state_q != ST_HOLD || xfer))
                busy_cnt <= BUSY_LOAD;
            else if (state_q == ST_HOLD && busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

    // Single write port: a host data byte takes precedence over the clear fill.
    logic       mem_we;
    logic [6:0] mem_waddr;
    logic [7:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = fill_cnt;
        mem_wdata = 8'h20;
        if (data_wr) begin
            mem_we    = 1'b1;
            mem_waddr = ddram_addr;
            mem_wdata = bus_d;
        end else if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (mem_we) ddram_mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) rd_data <= '0;
        else       rd_data <= ddram_mem[rd_addr];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cmd_valid      <= 1'b0;
            cmd_code       <= '0;
            data_valid     <= 1'b0;
            ddram_addr     <= LINE0_BASE;
            inc_q          <= 1'b1;
            display_on     <= 1'b0;
            cursor_on      <= 1'b0;
            blink_on       <= 1'b0;
            err_busy_write <= 1'b0;
            err_mode       <= 1'b0;
        end else begin
            cmd_valid  <= instr;
            data_valid <= data_wr;
            if (xfer && busy) err_busy_write <= 1'b1;
            if (data_wr) ddram_addr <= step_addr(ddram_addr, inc_q);
            if (instr) begin
                cmd_code <= bus_d;
                if ((bus_d & DDRAM) != 8'h00) begin
                    ddram_addr <= bus_d[6:0];
                end else if ((bus_d & CGRAM) != 8'h00) begin
                    ddram_addr <= ddram_addr;
                end else if ((bus_d & FUNC) != 8'h00) begin
                    if (!bus_d[4]) err_mode <= 1'b1;
                end else if ((bus_d & SHIFT) != 8'h00) begin
                    if (!bus_d[3]) ddram_addr <= step_addr(ddram_addr, bus_d[2]);
                end else if ((bus_d & DISP) != 8'h00) begin
                    display_on <= bus_d[2];
                    cursor_on  <= bus_d[1];
                    blink_on   <= bus_d[0];
                end else if ((bus_d & ENTRY) != 8'h00) begin
                    inc_q <= bus_d[1];
                end else if ((bus_d & HOME) != 8'h00) begin
                    ddram_addr <= LINE0_BASE;
                end else if ((bus_d & CLR) != 8'h00) begin
                    ddram_addr <= LINE0_BASE;
                    inc_q      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - directed self-checking bench for lcd_bus_receiver
module tb_lcd_bus_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_d = 8'h00;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data, cmd_code;
    logic [6:0] ddram_addr;
    logic       cmd_valid, data_valid, display_on, cursor_on, blink_on;
    logic       busy, err_busy_write, err_mode;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lcd_bus_receiver dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .lcd_e          (lcd_e),
        .lcd_rs         (lcd_rs),
        .lcd_rw         (lcd_rw),
        .lcd_d          (lcd_d),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .data_valid     (data_valid),
        .ddram_addr     (ddram_addr),
        .display_on     (display_on),
        .cursor_on      (cursor_on),
        .blink_on       (blink_on),
        .busy           (busy),
        .err_busy_write (err_busy_write),
        .err_mode       (err_mode)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns on the cycle the decoded pulse (if any) is visible.
    task automatic bus_write(input logic rs, input logic rw, input logic [7:0] b);
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_d  = b;
        lcd_e  = 1'b1;
        tick(2);
        lcd_e  = 1'b0;
        tick(3);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            if (!busy) return;
            tick(1);
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic read_ram(input logic [6:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        tick(1);
        check(tag, rd_data, exp);
    endtask

    task automatic write_idle(input logic rs, input logic [7:0] b);
        bus_write(rs, 1'b0, b);
        wait_idle();
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        check("rst_busy", busy, 1);
        check("rst_rd_data", rd_data, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_addr", ddram_addr, 0);
        check("rst_errs", {err_busy_write, err_mode}, 0);
        check("rst_disp", {display_on, cursor_on, blink_on}, 0);
        tick(2127);
        check("rst_busy_hold", busy, 1);
        tick(1);
        check("rst_busy_fall", busy, 0);
        read_ram(7'h00, 8'h20, "fill_00");
        read_ram(7'h4F, 8'h20, "fill_4f");
        read_ram(7'h7F, 8'h20, "fill_7f");

        write_idle(1'b0, 8'h38);
        write_idle(1'b0, 8'h0C);
        write_idle(1'b0, 8'h06);
        write_idle(1'b0, 8'h80);
        write_idle(1'b1, 8'h4C);
        write_idle(1'b1, 8'h46);
        write_idle(1'b1, 8'h4F);
        read_ram(7'h00, 8'h4C, "lfo_0");
        read_ram(7'h01, 8'h46, "lfo_1");
        read_ram(7'h02, 8'h4F, "lfo_2");
        check("lfo_addr", ddram_addr, 7'h03);
        check("lfo_disp", {display_on, cursor_on, blink_on}, 3'b100);
        check("lfo_errs", {err_busy_write, err_mode}, 0);

        write_idle(1'b0, 8'hA7);
        write_idle(1'b1, 8'h41);
        check("wrap_inc_addr", ddram_addr, 7'h40);
        read_ram(7'h27, 8'h41, "wrap_27");
        write_idle(1'b0, 8'h04);
        write_idle(1'b1, 8'h42);
        write_idle(1'b1, 8'h43);
        check("wrap_dec_addr", ddram_addr, 7'h26);
        read_ram(7'h40, 8'h42, "dec_40");
        read_ram(7'h27, 8'h43, "dec_27");

        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_d = 8'h44; lcd_e = 1'b1;
        tick(2);
        lcd_e = 1'b0;
        tick(2);
        check("strobe_early", data_valid, 0);
        tick(1);
        check("strobe_on", data_valid, 1);
        tick(1);
        check("strobe_off", data_valid, 0);
        bus_write(1'b1, 1'b0, 8'h45);
        check("busy_err", err_busy_write, 1);
        tick(1999);
        check("busy_reload_hold", busy, 1);
        tick(1);
        check("busy_reload_fall", busy, 0);
        read_ram(7'h26, 8'h44, "busy_first");
        read_ram(7'h25, 8'h45, "busy_second");
        check("busy_addr", ddram_addr, 7'h24);

        bus_write(1'b0, 1'b0, 8'h28);
        check("func_cmd_valid", cmd_valid, 1);
        check("func_cmd_code", cmd_code, 8'h28);
        wait_idle();
        check("func_err_mode", err_mode, 1);

        bus_write(1'b1, 1'b1, 8'h99);
        check("rw_pulses", {cmd_valid, data_valid}, 0);
        tick(4);
        check("rw_busy", busy, 0);
        check("rw_addr", ddram_addr, 7'h24);
        read_ram(7'h24, 8'h20, "rw_mem");

        write_idle(1'b0, 8'h06);
        write_idle(1'b0, 8'hE7);
        write_idle(1'b1, 8'h31);
        check("wrap_67", ddram_addr, 7'h00);
        write_idle(1'b0, 8'hB0);
        check("unmapped_set", ddram_addr, 7'h30);
        write_idle(1'b1, 8'h32);
        check("unmapped_step", ddram_addr, 7'h00);
        read_ram(7'h30, 8'h32, "unmapped_mem");

        bus_write(1'b1, 1'b0, 8'h5A);
        read_ram(7'h00, 8'h5A, "pre_reset_mem");
        tick(100);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_busy", busy, 1);
        check("midrst_errs", {err_busy_write, err_mode}, 0);
        check("midrst_addr", ddram_addr, 0);
        tick(130);
        check("midrst_hold", busy, 1);
        read_ram(7'h00, 8'h20, "midrst_mem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
